// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply sequencer built around an external 4x4 combinational
// multiplier. Four nibble partial products are issued over four MUL cycles,
// shifted and summed into a 16-bit accumulator, then handed off over a
// valid/ready result port. A saturating counter tracks completed handoffs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; latches operands on start handshake
// MUL   | steps 0..3, one partial product accumulated per cycle
// DONE  | result presented on res/res_valid until res_ready
module mul8_seq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res,
    output logic [3:0]       mul_ina,
    output logic [3:0]       mul_inb,
    input  logic [7:0]       mul_out,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      res_q, res_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [15:0]      pp_shifted;
    logic [15:0]      acc_sum;

    // Nibble selection for the external multiplier and alignment of its product.
    // The multiplier inputs are parked at zero outside MUL.
    always_comb begin
        mul_ina    = 4'd0;
        mul_inb    = 4'd0;
        pp_shifted = 16'd0;
        if (state_q == S_MUL) begin
            case (step_q)
                2'd0: begin
                    mul_ina    = a_q[3:0];
                    mul_inb    = b_q[3:0];
                    pp_shifted = {8'd0, mul_out};
                end
                2'd1: begin
                    mul_ina    = a_q[7:4];
                    mul_inb    = b_q[3:0];
                    pp_shifted = {4'd0, mul_out, 4'd0};
                end
                2'd2: begin
                    mul_ina    = a_q[3:0];
                    mul_inb    = b_q[7:4];
                    pp_shifted = {4'd0, mul_out, 4'd0};
                end
                default: begin
                    mul_ina    = a_q[7:4];
                    mul_inb    = b_q[7:4];
                    pp_shifted = {mul_out, 8'd0};
                end
            endcase
        end
    end

    // The final sum never exceeds 0xFE01, so 16-bit truncation loses nothing.
    assign acc_sum = acc_q + pp_shifted;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        res_d      = res_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'd0;
                    step_d  = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    // res is a separate register so it keeps the previous
                    // result while the next operation rebuilds acc from zero.
                    res_d   = acc_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                    if (op_count_q != {CNT_W{1'b1}}) begin
                        op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 2'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            acc_q      <= 16'd0;
            res_q      <= 16'd0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            op_count_q <= op_count_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_MUL);
    assign res_valid   = (state_q == S_DONE);
    assign res         = res_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
Sequencing controller that computes an 8x8 unsigned product using the team's existing 4x4 combinational multiplier. The multiplier sits outside this block and is driven through the mul_* ports. The block splits the operands into nibbles and issues four partial products over four cycles. It accumulates the shifted partial products and returns a 16-bit result over a valid/ready handshake. It also keeps a saturating count of completed operations.

Parameters:
CNT_W, 8, width of the completed-operation counter op_count; the counter saturates at all-ones.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  request carries valid operands
start_ready  output  1  block can accept a request
a  input  8  multiplicand, unsigned
b  input  8  multiplier, unsigned
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res  output  16  product a*b
mul_ina  output  4  operand A to the external 4x4 multiplier
mul_inb  output  4  operand B to the external 4x4 multiplier
mul_out  input  8  product from the external multiplier (combinational, same cycle)
busy  output  1  high in MUL state
op_count  output  CNT_W  number of results handed off, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; step counter, operand registers, acc and op_count clear to 0.
  - Outputs: start_ready=1, res_valid=0, res=0, busy=0, mul_ina=mul_inb=0.
- States: IDLE, MUL, DONE.
- IDLE:
  - start_ready=1.
  - When start_valid is high at an edge: latch a and b, clear acc to 0, set step=0, go to MUL.
  - start_valid low: stay in IDLE. Operands are ignored unless a handshake occurs.
- MUL:
  - busy=1, start_ready=0. start_valid is ignored and no operand is latched.
  - mul_ina/mul_inb are driven combinationally from the latched operands and step:
    - step0: a[3:0], b[3:0]; shift 0
    - step1: a[7:4], b[3:0]; shift 4
    - step2: a[3:0], b[7:4]; shift 4
    - step3: a[7:4], b[7:4]; shift 8
  - At each edge: acc <= acc + ({8'b0, mul_out} << shift), truncated to 16 bits; step increments.
  - The 16-bit acc cannot overflow (maximum 0xFE01).
  - At the step3 edge: go to DONE.
- DONE:
  - res_valid=1; res=acc, held stable while res_ready is low.
  - mul_ina=mul_inb=0; start_ready=0.
  - At an edge with res_ready high: go to IDLE, res_valid drops. If op_count != all-ones, increment op_count.
- Latency:
  - Accept edge E0; accumulation at edges E1 through E4.
  - res_valid goes high after E4, i.e. 4 cycles after accept.
  - Minimum request-to-request spacing is 6 cycles (4 MUL + at least 1 DONE + 1 IDLE).
- Outside DONE:
  - res holds the last completed value.
  - res_valid is never high outside DONE.
- Simultaneous events: a request arriving in the same cycle as a DONE handoff is not accepted; it is accepted in the following IDLE cycle if still valid.
- op_count wrap-around: never; it sticks at 2^CNT_W-1.
- Reset mid-operation (MUL or DONE): the partial result is discarded, all registers clear immediately, and no result is delivered.
- mul_out is sampled only in MUL; its value in other states has no effect.

Test Plan:
- Reset, then a=0x12, b=0x34 with res_ready=1 -> res_valid rises 4 cycles after accept; res=0x03A8; op_count=1.
- a=0xFF, b=0xFF -> mul_ina/mul_inb sequence F/F for all four steps; res=0xFE01.
- a=0x00, b=0xA7, then a=0x01, b=0x01 -> res=0x0000, then res=0x0001; start_ready low throughout MUL and DONE.
- Backpressure: a=0x80, b=0x02, res_ready held low for 10 cycles -> res=0x0100 stable with res_valid high; a new start_valid is not accepted; handoff on the first res_ready=1 edge.
- Drop rst_n during step2 of a=0x55, b=0xAA -> all outputs return to reset values asynchronously; after release, the next op a=0x03, b=0x05 gives 0x000F.
- CNT_W=2: five completed operations -> op_count reads 1, 2, 3, 3, 3.
